df_tap_accumulator: RTL and testbench

Sequential accumulator that sums a burst of signed 9-bit terms, each added or subtracted, into one filter output sample. It sits directly downstream of the digital filter's 9-bit adder/subtractor and closes the loop around it. It feeds the running sum back as operand `a`, presents the incoming term as `b` with its `sub` flag, and registers the result. Completed sums go to the filter output stage through a valid/ready handshake.

---
 rtl/df_pkg.sv | 14 +
 rtl/df_adder_subtractor.sv | 13 +
 rtl/df_tap_accumulator.sv | 122 ++++++++++++
 tb/tb_df_tap_accumulator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/df_pkg.sv
// rtl/df_pkg.sv - shared widths, limits and FSM state type for the filter tap accumulator
package df_pkg;

    localparam int DF_W = 9;
    localparam logic signed [DF_W-1:0] DF_MAX = 9'sd255;
    localparam logic signed [DF_W-1:0] DF_MIN = -9'sd256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } df_acc_state_t;

endpackage

// File: rtl/df_adder_subtractor.sv
// rtl/df_adder_subtractor.sv - 9-bit adder/subtractor: out = a + (b ^ {9{sub}}) + sub
module df_adder_subtractor
    import df_pkg::*;
(
    input  logic [DF_W-1:0] a,
    input  logic [DF_W-1:0] b,
    input  logic            sub,
    output logic [DF_W-1:0] out
);

    assign out = a + (b ^ {DF_W{sub}}) + {{(DF_W-1){1'b0}}, sub};

endmodule

// File: rtl/df_tap_accumulator.sv
// rtl/df_tap_accumulator.sv - frame accumulator of signed 9-bit terms with valid/ready output
// Optional build macro DF_ACC_SATURATE_EN clamps overflowing steps instead of wrapping.
module df_tap_accumulator
    import df_pkg::*;
#(
    parameter  int MAX_TAPS = 8,
    localparam int CW       = $clog2(MAX_TAPS) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic signed [DF_W-1:0] in_data,
    input  logic                   in_sub,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [DF_W-1:0] acc_out,
    output logic [CW-1:0]          tap_count,
    output logic                   ovf,
    output logic                   overrun
);

    df_acc_state_t          state_q;
    logic signed [DF_W-1:0] acc_q;
    logic [CW-1:0]          tap_q;
    logic                   ovf_q;
    logic                   overrun_q;
    logic                   out_valid_q;

    logic [DF_W-1:0]        op_a;
    logic [DF_W-1:0]        op_b_eff;
    logic [DF_W-1:0]        sum;
    logic                   step_ovf;
    logic signed [DF_W-1:0] acc_d;
    logic [CW-1:0]          tap_d;
    logic                   hit_max;

    // A new frame starts from zero, so the first term never sees a stale sum.
    assign op_a = (state_q == IDLE) ? '0 : acc_q;

    df_adder_subtractor u_addsub (
        .a   (op_a),
        .b   (in_data),
        .sub (in_sub),
        .out (sum)
    );

    assign op_b_eff = in_data ^ {DF_W{in_sub}};
    assign step_ovf = (op_a[DF_W-1] == op_b_eff[DF_W-1]) && (sum[DF_W-1] != op_a[DF_W-1]);

`ifdef DF_ACC_SATURATE_EN
    // Both operands share a sign on overflow, so op_a's sign gives the clamp direction.
    assign acc_d = step_ovf ? (op_a[DF_W-1] ? DF_MIN : DF_MAX) : $signed(sum);
`else
    assign acc_d = $signed(sum);
`endif

    assign tap_d   = (state_q == IDLE) ? CW'(1) : tap_q + CW'(1);
    assign hit_max = (tap_d == CW'(MAX_TAPS));

    assign in_ready  = (state_q != DONE);
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign tap_count = tap_q;
    assign ovf       = ovf_q;
    assign overrun   = overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tap_q       <= '0;
            ovf_q       <= 1'b0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q     <= acc_d;
                        tap_q     <= tap_d;
                        ovf_q     <= step_ovf;
                        overrun_q <= 1'b0;
                        if (in_last) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        tap_q <= tap_d;
                        ovf_q <= ovf_q | step_ovf;
                        if (in_last) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else if (hit_max) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            overrun_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_df_tap_accumulator.sv
// tb/tb_df_tap_accumulator.sv - self-checking bench for df_tap_accumulator
module tb_df_tap_accumulator;

    localparam int MAX_TAPS = 8;
    localparam int CW       = $clog2(MAX_TAPS) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic signed [8:0] in_data;
    logic              in_sub;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic signed [8:0] acc_out;
    logic [CW-1:0]     tap_count;
    logic              ovf;
    logic              overrun;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int n;
        int t[8];
        bit s[8];
        bit last;
        int exp_acc;
        int exp_taps;
        bit exp_ovf;
        bit exp_ovr;
    } frame_t;

    frame_t tbl[6];

    df_tap_accumulator #(.MAX_TAPS(MAX_TAPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .tap_count (tap_count),
        .ovf       (ovf),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain integer reference: exact sum per step, then wrap or clamp into 9-bit range.
    task automatic model(input frame_t f, output int acc, output bit ov);
        int s;
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < f.n; i++) begin
            s = f.s[i] ? acc - f.t[i] : acc + f.t[i];
            if (s > 255 || s < -256) begin
                ov = 1'b1;
`ifdef DF_ACC_SATURATE_EN
                s = (s > 255) ? 255 : -256;
`else
                s = ((s + 256 + 1024) % 512) - 256;
`endif
            end
            acc = s;
        end
    endtask

    task automatic drive_frame(input frame_t f, input bit gaps);
        int v;
        for (int i = 0; i < f.n; i++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                in_valid = 1'b0;
                tick();
            end
            v        = f.t[i];
            in_valid = 1'b1;
            in_data  = v[8:0];
            in_sub   = f.s[i];
            in_last  = f.last && (i == f.n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_out(input string tag, input frame_t f);
        check({tag, ".out_valid"}, int'(out_valid), 1);
        check({tag, ".in_ready"},  int'(in_ready),  0);
        check({tag, ".acc_out"},   int'(acc_out),   f.exp_acc);
        check({tag, ".tap_count"}, int'(tap_count), f.exp_taps);
        check({tag, ".ovf"},       int'(ovf),       int'(f.exp_ovf));
        check({tag, ".overrun"},   int'(overrun),   int'(f.exp_ovr));
    endtask

    task automatic release_out(input string tag, input int delay);
        for (int d = 0; d < delay; d++) begin
            out_ready = 1'b0;
            tick();
            check({tag, ".held_valid"}, int'(out_valid), 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".rel_valid"}, int'(out_valid), 0);
        check({tag, ".rel_ready"}, int'(in_ready),  1);
    endtask

    function automatic frame_t mk(input int n, input bit last);
        frame_t f;
        f.n = n;
        f.last = last;
        for (int i = 0; i < 8; i++) begin
            f.t[i] = 0;
            f.s[i] = 1'b0;
        end
        f.exp_acc = 0; f.exp_taps = n; f.exp_ovf = 1'b0; f.exp_ovr = 1'b0;
        return f;
    endfunction

    initial begin
        frame_t f;
        int     macc;
        bit     mov;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0;
        in_last = 1'b0; out_ready = 1'b0;

        tbl[0] = mk(3, 1'b1);
        tbl[0].t[0] = 72; tbl[0].t[1] = 58; tbl[0].t[2] = 46; tbl[0].s[2] = 1'b1;
        tbl[0].exp_acc = 84;
        tbl[1] = mk(2, 1'b1);
        tbl[1].t[0] = 200; tbl[1].t[1] = 100; tbl[1].exp_ovf = 1'b1;
        tbl[2] = mk(2, 1'b1);
        tbl[2].t[0] = -200; tbl[2].t[1] = 100; tbl[2].s[1] = 1'b1; tbl[2].exp_ovf = 1'b1;
        tbl[3] = mk(8, 1'b0);
        for (int i = 0; i < 8; i++) tbl[3].t[i] = 1;
        tbl[3].exp_acc = 8; tbl[3].exp_ovr = 1'b1;
        tbl[4] = mk(8, 1'b1);
        for (int i = 0; i < 8; i++) tbl[4].t[i] = 1;
        tbl[4].exp_acc = 8;
        tbl[5] = mk(1, 1'b1);
        tbl[5].t[0] = -256; tbl[5].s[0] = 1'b1; tbl[5].exp_ovf = 1'b1;
`ifdef DF_ACC_SATURATE_EN
        tbl[1].exp_acc = 255; tbl[2].exp_acc = -256; tbl[5].exp_acc = 255;
`else
        tbl[1].exp_acc = -212; tbl[2].exp_acc = 212; tbl[5].exp_acc = -256;
`endif

        tick(); tick();
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.acc_out",   int'(acc_out),   0);
        check("rst.tap_count", int'(tap_count), 0);
        check("rst.ovf",       int'(ovf),       0);
        check("rst.overrun",   int'(overrun),   0);
        rst_n = 1'b1;
        tick();
        check("rst.in_ready",  int'(in_ready),  1);

        for (int k = 0; k < 6; k++) begin
            drive_frame(tbl[k], 1'b0);
            check_out($sformatf("vec%0d", k), tbl[k]);
            release_out($sformatf("vec%0d", k), 0);
        end

        // DONE holds off new terms while the consumer stalls.
        drive_frame(tbl[0], 1'b0);
        in_valid = 1'b1; in_data = 9'sd5; in_sub = 1'b0; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold.in_ready",  int'(in_ready),  0);
            check("hold.out_valid", int'(out_valid), 1);
            check("hold.acc_out",   int'(acc_out),   84);
            check("hold.tap_count", int'(tap_count), 3);
        end
        in_valid = 1'b0; in_last = 1'b0;
        release_out("hold", 0);
        f = mk(1, 1'b1);
        f.t[0] = 127; f.exp_acc = 127;
        drive_frame(f, 1'b0);
        check_out("after_hold", f);
        release_out("after_hold", 0);

        // Reset in the middle of a frame discards the partial sum.
        f = mk(2, 1'b0);
        f.t[0] = 30; f.t[1] = 40;
        drive_frame(f, 1'b0);
        rst_n = 1'b0;
        tick();
        check("midrst.out_valid", int'(out_valid), 0);
        check("midrst.acc_out",   int'(acc_out),   0);
        check("midrst.in_ready",  int'(in_ready),  1);
        check("midrst.tap_count", int'(tap_count), 0);
        rst_n = 1'b1;
        f = mk(2, 1'b1);
        drive_frame(f, 1'b0);
        check_out("zero_frame", f);
        release_out("zero_frame", 1);

        for (int r = 0; r < 40; r++) begin
            f = mk(int'($urandom_range(1, 8)), 1'b1);
            if (f.n == 8) f.last = bit'($urandom % 2);
            for (int i = 0; i < f.n; i++) begin
                f.t[i] = int'($urandom_range(0, 511)) - 256;
                f.s[i] = bit'($urandom % 2);
            end
            model(f, macc, mov);
            f.exp_acc = macc;
            f.exp_ovf = mov;
            f.exp_ovr = (f.n == MAX_TAPS) && !f.last;
            drive_frame(f, 1'b1);
            check_out($sformatf("rnd%0d", r), f);
            release_out($sformatf("rnd%0d", r), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
